// File: rtl/buyruk_sirala_pkg.sv
// bib_paket: shared ALU opcode constants and issuer FSM states
package bib_paket;
  localparam logic [2:0] TOPLA      = 3'b000;
  localparam logic [2:0] CIKAR      = 3'b001;
  localparam logic [2:0] B_AND      = 3'b010;
  localparam logic [2:0] B_OR       = 3'b011;
  localparam logic [2:0] AND_R      = 3'b100;
  localparam logic [2:0] OR_R       = 3'b101;
  localparam logic [2:0] CIFT_ESLIK = 3'b110;
  localparam logic [2:0] TEK_ESLIK  = 3'b111;
  typedef enum logic [1:0] {BOS, BEKLE, SONUC} durum_t;
endpackage

// File: rtl/buyruk_sirala_fifo.sv
// buyruk_fifo: instruction FIFO; full/empty come from the occupancy count
module buyruk_fifo #(
  parameter int DERINLIK = 4,
  parameter int W = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic [W-1:0]                  din,
  output logic [W-1:0]                  dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(DERINLIK):0]     count
);
  localparam int AW = $clog2(DERINLIK);
  logic [W-1:0] mem [DERINLIK];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign full = count == (AW+1)'(DERINLIK);
  assign empty = count == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/buyruk_sirala.sv
// buyruk_sirala: queues 9-bit ALU instructions, issues them one at a time and returns each result
module buyruk_sirala
  import bib_paket::*;
#(
  parameter int DERINLIK = 4,
  parameter int ALU_GECIKME = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [8:0]                 in_buyruk,
  output logic                       in_ready,
  output logic [8:0]                 alu_buyruk,
  input  logic [3:0]                 alu_sonuc,
  output logic                       out_valid,
  output logic [3:0]                 out_sonuc,
  output logic [2:0]                 out_op,
  input  logic                       out_ready,
  output logic [$clog2(DERINLIK):0]  dolu_say,
  output logic [7:0]                 tamam_say,
  output logic                       mesgul
);
  localparam int SW = $clog2(ALU_GECIKME + 1);
  durum_t durum, sonraki;
  logic [SW-1:0] sayac;
  logic [8:0] bas;
  logic dolu, bos, pop;
  buyruk_fifo #(.DERINLIK(DERINLIK), .W(9)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(in_valid), .pop(pop), .din(in_buyruk),
    .dout(bas), .full(dolu), .empty(bos), .count(dolu_say)
  );
  assign in_ready = !dolu;
  assign pop = durum == BOS && !bos;
  assign mesgul = durum != BOS || !bos;
  always_comb
    sonraki = durum == BOS   ? (bos ? BOS : BEKLE) :
              durum == BEKLE ? (sayac == SW'(1) ? SONUC : BEKLE) :
                               (out_ready ? BOS : SONUC);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) durum <= BOS;
    else durum <= sonraki;
  // alu_buyruk only changes on a pop so the ALU input never glitches
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_buyruk <= '0;
      sayac <= '0;
      out_valid <= 1'b0;
      out_sonuc <= '0;
      out_op <= '0;
      tamam_say <= '0;
    end else begin
      if (pop) begin
        alu_buyruk <= bas;
        sayac <= SW'(ALU_GECIKME);
      end
      if (durum == BEKLE) begin
        if (sayac == SW'(1)) begin
          out_sonuc <= alu_sonuc;
          out_op <= alu_buyruk[8:6];
          out_valid <= 1'b1;
        end else sayac <= sayac - SW'(1);
      end
      if (durum == SONUC && out_ready) begin
        out_valid <= 1'b0;
        tamam_say <= tamam_say + 8'd1;
      end
    end
endmodule

// File: tb/tb_buyruk_sirala.sv
// tb_buyruk_sirala: randomized checks of the issuer against an ALU model and an in-order result queue
module tb_buyruk_sirala;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  logic [7:0] tam = 8'd0;
  logic [8:0] q[$];
  logic iv1 = 1'b0, or1 = 1'b1, ir1, ov1, m1;
  logic [8:0] ib1 = '0, ab1;
  logic [3:0] as1, os1;
  logic [2:0] oo1;
  logic [2:0] ds1;
  logic [7:0] ts1;
  logic iv3 = 1'b0, or3 = 1'b1, ir3, ov3, m3;
  logic [8:0] ib3 = '0, ab3;
  logic [3:0] as3, os3;
  logic [2:0] oo3;
  logic [2:0] ds3;
  logic [7:0] ts3;

  function automatic logic [3:0] alu_f(input logic [8:0] b);
    logic [3:0] x, y;
    x = {1'b0, b[5:3]};
    y = {1'b0, b[2:0]};
    case (b[8:6])
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return {3'b0, &b[2:0]};
      3'd5: return {3'b0, |b[2:0]};
      3'd6: return {3'b0, ^b[2:0]};
      default: return {3'b0, ~^b[2:0]};
    endcase
  endfunction

  assign as1 = alu_f(ab1);
  assign as3 = alu_f(ab3);

  buyruk_sirala #(.DERINLIK(4), .ALU_GECIKME(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_buyruk(ib1), .in_ready(ir1),
    .alu_buyruk(ab1), .alu_sonuc(as1), .out_valid(ov1), .out_sonuc(os1), .out_op(oo1),
    .out_ready(or1), .dolu_say(ds1), .tamam_say(ts1), .mesgul(m1)
  );
  buyruk_sirala #(.DERINLIK(4), .ALU_GECIKME(3)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_buyruk(ib3), .in_ready(ir3),
    .alu_buyruk(ab3), .alu_sonuc(as3), .out_valid(ov3), .out_sonuc(os3), .out_op(oo3),
    .out_ready(or3), .dolu_say(ds3), .tamam_say(ts3), .mesgul(m3)
  );

  task automatic drain();
    int n = 0;
    or1 = 1'b1;
    iv1 = 1'b0;
    while ((q.size() != 0 || m1) && n < 400) begin
      if (ov1) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL drain_extra got=%h exp=none", {oo1, os1});
        end else begin
          if ({oo1, os1} !== {q[0][8:6], alu_f(q[0])}) begin
            fails++;
            $display("FAIL drain_result got=%h exp=%h", {oo1, os1}, {q[0][8:6], alu_f(q[0])});
          end
          void'(q.pop_front());
        end
        tam++;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (q.size() != 0 || m1) begin
      fails++;
      $display("FAIL drain_timeout got=%0d pending exp=0", q.size());
      q.delete();
    end
    checks++;
    if (ts1 !== tam) begin
      fails++;
      $display("FAIL tamam_say got=%0d exp=%0d", ts1, tam);
    end
  endtask

  task automatic test_reset();
    logic [8:0] a;
    #1;
    checks++;
    if ({ov1, ds1, ts1, ab1, os1, oo1, m1, ir1} !== {1'b0, 3'd0, 8'd0, 9'd0, 4'd0, 3'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got=%h exp=%h", {ov1, ds1, ts1, ab1, os1, oo1, m1, ir1},
               {1'b0, 3'd0, 8'd0, 9'd0, 4'd0, 3'd0, 1'b0, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    or3 = 1'b0;
    a = 9'($urandom) | 9'h008;
    for (int i = 0; i < 3; i++) begin
      iv3 = 1'b1;
      ib3 = (i == 0) ? a : 9'($urandom);
      @(negedge clk);
    end
    iv3 = 1'b0;
    checks++;
    if ({ds3, ab3, ov3} !== {3'd2, a, 1'b0}) begin
      fails++;
      $display("FAIL mid_bekle got=%h exp=%h", {ds3, ab3, ov3}, {3'd2, a, 1'b0});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov3, ds3, ts3, ab3, m3} !== {1'b0, 3'd0, 8'd0, 9'd0, 1'b0}) begin
      fails++;
      $display("FAIL async_reset got=%h exp=%h", {ov3, ds3, ts3, ab3, m3}, 22'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    or3 = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({ov3, m3, ts3} !== 10'd0) begin
      fails++;
      $display("FAIL reset_discard got=%h exp=0", {ov3, m3, ts3});
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    iv1 = 1'b1;
    ib1 = 9'b000_011_101;
    or1 = 1'b1;
    @(negedge clk);
    iv1 = 1'b0;
    checks++;
    if ({ov1, ds1} !== {1'b0, 3'd1}) begin
      fails++;
      $display("FAIL single_e0 got=%h exp=%h", {ov1, ds1}, {1'b0, 3'd1});
    end
    @(negedge clk);
    checks++;
    if ({ov1, ab1, ds1} !== {1'b0, 9'b000_011_101, 3'd0}) begin
      fails++;
      $display("FAIL single_e1 got=%h exp=%h", {ov1, ab1, ds1}, {1'b0, 9'b000_011_101, 3'd0});
    end
    @(negedge clk);
    checks++;
    if ({ov1, os1, oo1} !== {1'b1, 4'd8, 3'b000}) begin
      fails++;
      $display("FAIL single_e2 got=%h exp=%h", {ov1, os1, oo1}, {1'b1, 4'd8, 3'b000});
    end
    tam++;
    @(negedge clk);
    checks++;
    if ({ov1, ts1} !== {1'b0, tam}) begin
      fails++;
      $display("FAIL single_done got=%h exp=%h", {ov1, ts1}, {1'b0, tam});
    end
  endtask

  task automatic test_fill();
    or1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iv1 = 1'b1;
      ib1 = 9'($urandom);
      checks++;
      if (ir1 !== 1'b1) begin
        fails++;
        $display("FAIL fill_ready%0d got=%b exp=1", i, ir1);
      end
      q.push_back(ib1);
      @(negedge clk);
    end
    iv1 = 1'b0;
    checks++;
    if ({ds1, ir1, ov1} !== {3'd4, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL fill_full got=%h exp=%h", {ds1, ir1, ov1}, {3'd4, 1'b0, 1'b1});
    end
    iv1 = 1'b1;
    ib1 = 9'($urandom);
    @(negedge clk);
    iv1 = 1'b0;
    checks++;
    if ({ds1, ir1} !== {3'd4, 1'b0}) begin
      fails++;
      $display("FAIL fill_refuse got=%h exp=%h", {ds1, ir1}, {3'd4, 1'b0});
    end
    drain();
  endtask

  task automatic test_backpressure();
    int n = 0;
    or1 = 1'b0;
    iv1 = 1'b1;
    ib1 = 9'b001_010_101;
    @(negedge clk);
    iv1 = 1'b0;
    ib1 = 9'($urandom);
    while (!ov1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({ov1, os1, oo1, ab1} !== {1'b1, 4'b1101, 3'b001, 9'b001_010_101}) begin
        fails++;
        $display("FAIL backpressure%0d got=%h exp=%h", i, {ov1, os1, oo1, ab1},
                 {1'b1, 4'b1101, 3'b001, 9'b001_010_101});
      end
      @(negedge clk);
    end
    q.push_back(9'b001_010_101);
    drain();
  endtask

  task automatic test_simul();
    int n = 0;
    logic [2:0] d;
    or1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv1 = 1'b1;
      ib1 = 9'($urandom);
      q.push_back(ib1);
      @(negedge clk);
    end
    iv1 = 1'b0;
    while (!ov1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ({ov1, ds1, oo1, os1} !== {1'b1, 3'd2, q[0][8:6], alu_f(q[0])}) begin
      fails++;
      $display("FAIL simul_first got=%h exp=%h", {ov1, ds1, oo1, os1}, {1'b1, 3'd2, q[0][8:6], alu_f(q[0])});
    end
    void'(q.pop_front());
    tam++;
    or1 = 1'b1;
    @(negedge clk);
    or1 = 1'b0;
    d = ds1;
    iv1 = 1'b1;
    ib1 = 9'($urandom);
    q.push_back(ib1);
    @(negedge clk);
    iv1 = 1'b0;
    checks++;
    if ({ds1, ab1} !== {d, q[0]}) begin
      fails++;
      $display("FAIL simul_pushpop got=%h exp=%h", {ds1, ab1}, {d, q[0]});
    end
    drain();
  endtask

  task automatic test_settle();
    @(negedge clk);
    iv3 = 1'b1;
    ib3 = 9'b111_000_011;
    or3 = 1'b1;
    @(negedge clk);
    iv3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ov3 !== 1'b0) begin
        fails++;
        $display("FAIL settle_early%0d got=%b exp=0", k, ov3);
      end
      @(negedge clk);
    end
    checks++;
    if ({ov3, os3, oo3} !== {1'b1, 4'b0001, 3'b111}) begin
      fails++;
      $display("FAIL settle_capture got=%h exp=%h", {ov3, os3, oo3}, {1'b1, 4'b0001, 3'b111});
    end
    @(negedge clk);
    checks++;
    if ({ov3, ts3} !== {1'b0, 8'd1}) begin
      fails++;
      $display("FAIL settle_done got=%h exp=%h", {ov3, ts3}, {1'b0, 8'd1});
    end
  endtask

  task automatic traffic(input int n);
    int pushed = 0, cyc = 0;
    while (pushed < n && cyc < 20 * n) begin
      if (ov1) begin
        checks++;
        if (q.size() == 0 || {oo1, os1} !== {q[0][8:6], alu_f(q[0])}) begin
          fails++;
          $display("FAIL traffic_result got=%h exp=%h", {oo1, os1}, q.size() ? {q[0][8:6], alu_f(q[0])} : 7'h0);
        end
      end
      or1 = 1'($urandom_range(0, 1));
      if (ov1 && or1 && q.size() != 0) begin
        void'(q.pop_front());
        tam++;
      end
      iv1 = 1'($urandom_range(0, 1));
      ib1 = 9'($urandom);
      if (iv1 && ir1) begin
        q.push_back(ib1);
        pushed++;
      end
      @(negedge clk);
      cyc++;
    end
    iv1 = 1'b0;
    checks++;
    if (pushed < n) begin
      fails++;
      $display("FAIL traffic_timeout got=%0d exp=%0d", pushed, n);
    end
    drain();
  endtask

  task automatic test_wrap();
    traffic((tam == 8'd0) ? 256 : 256 - int'(tam));
    checks++;
    if (ts1 !== 8'd0) begin
      fails++;
      $display("FAIL wrap got=%0d exp=0", ts1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_backpressure();
    test_simul();
    test_settle();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
